// File: rtl/mmio_series_accel_pkg.sv
// Shared definitions for the memory-mapped power-series accelerator:
// register offsets, mode/state encodings and status/config bit positions.
package mmio_series_accel_pkg;

    localparam logic [31:0] OFF_OP     = 32'h00;
    localparam logic [31:0] OFF_ANS    = 32'h04;
    localparam logic [31:0] OFF_CTRL   = 32'h08;
    localparam logic [31:0] OFF_NTERMS = 32'h0C;
    localparam logic [31:0] OFF_CFG    = 32'h10;
    localparam logic [31:0] OFF_STATUS = 32'h14;

    typedef enum logic {
        MODE_SUM = 1'b0,
        MODE_POW = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int STAT_DONE = 0;
    localparam int STAT_OVF  = 1;
    localparam int STAT_BUSY = 2;

    localparam int CFG_MODE = 0;
    localparam int CFG_IEN  = 1;

endpackage

// File: rtl/series_datapath.sv
// Series accumulator: holds ANS, the running term x^k and the term index k.
// o_ovf flags a carry or product overflow for the step being taken this cycle.
module series_datapath
    import mmio_series_accel_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_step,
    input  mode_e             i_mode,
    input  logic [DATA_W-1:0] i_x,
    input  logic [CNT_W-1:0]  i_n,
    output logic [DATA_W-1:0] o_ans,
    output logic              o_ovf,
    output logic              o_last
);

    logic [DATA_W-1:0]   r_ans;
    logic [DATA_W-1:0]   r_term;
    logic [CNT_W-1:0]    r_k;
    logic [DATA_W:0]     w_sum;
    logic [2*DATA_W-1:0] w_prod;
    logic                w_carry;
    logic                w_prod_hi;

    assign w_sum     = {1'b0, r_ans} + {1'b0, r_term};
    assign w_prod    = {{DATA_W{1'b0}}, r_term} * {{DATA_W{1'b0}}, i_x};
    assign w_carry   = (i_mode == MODE_SUM) && w_sum[DATA_W];
    assign w_prod_hi = |w_prod[2*DATA_W-1:DATA_W];

    assign o_ans  = r_ans;
    assign o_last = (r_k == i_n);
    assign o_ovf  = i_step && (w_carry || w_prod_hi);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ans  <= '0;
            r_term <= '0;
            r_k    <= '0;
        end else if (i_load) begin
            r_ans  <= DATA_W'(1);
            r_term <= i_x;
            r_k    <= CNT_W'(1);
        end else if (i_step) begin
            r_ans  <= (i_mode == MODE_SUM) ? w_sum[DATA_W-1:0] : r_term;
            r_term <= w_prod[DATA_W-1:0];
            r_k    <= r_k + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mmio_series_accel.sv
// Bus-mapped power-series accelerator: address decode, config/status registers,
// IDLE/RUN sequencer and completion interrupt around series_datapath.
module mmio_series_accel
    import mmio_series_accel_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          MAX_TERMS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       MemBus_Address,
    input  logic [DATA_W-1:0] MemBus_Write_Data,
    output logic [DATA_W-1:0] Device_Read_Data,
    output logic              irq
);

    localparam int CNT_W = $clog2(MAX_TERMS + 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [DATA_W-1:0] r_op;
    logic [CNT_W-1:0]  r_nterms;
    mode_e             r_mode;
    logic              r_ien;
    logic              r_done;
    logic              r_ovf;
    logic              r_irq;

    logic w_hit_op, w_hit_ans, w_hit_ctrl, w_hit_nterms, w_hit_cfg, w_hit_status;
    logic w_busy, w_cfg_wr, w_start, w_w1c;
    logic w_load, w_step, w_finish;
    logic w_dp_ovf, w_dp_last;
    logic [DATA_W-1:0] w_ans;
    logic [CNT_W-1:0]  w_n_clamped;
    logic [DATA_W-1:0] w_rdata;

    assign w_hit_op     = (MemBus_Address == BASE_ADDR + OFF_OP);
    assign w_hit_ans    = (MemBus_Address == BASE_ADDR + OFF_ANS);
    assign w_hit_ctrl   = (MemBus_Address == BASE_ADDR + OFF_CTRL);
    assign w_hit_nterms = (MemBus_Address == BASE_ADDR + OFF_NTERMS);
    assign w_hit_cfg    = (MemBus_Address == BASE_ADDR + OFF_CFG);
    assign w_hit_status = (MemBus_Address == BASE_ADDR + OFF_STATUS);

    // Operand/config registers are frozen while a run is in flight; only W1C gets through.
    assign w_busy   = (r_state == ST_RUN);
    assign w_cfg_wr = MemWrite && !w_busy;
    assign w_start  = w_cfg_wr && w_hit_ctrl && MemBus_Write_Data[0];
    assign w_w1c    = MemWrite && w_hit_status;

    always_comb begin
        w_n_clamped = MemBus_Write_Data[CNT_W-1:0];
        if (MemBus_Write_Data == '0)
            w_n_clamped = CNT_W'(1);
        else if (MemBus_Write_Data > DATA_W'(MAX_TERMS))
            w_n_clamped = CNT_W'(MAX_TERMS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_dp_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_nterms <= CNT_W'(5);
            r_mode   <= MODE_SUM;
            r_ien    <= 1'b0;
        end else if (w_cfg_wr) begin
            if (w_hit_op)
                r_op <= MemBus_Write_Data;
            if (w_hit_nterms)
                r_nterms <= w_n_clamped;
            if (w_hit_cfg) begin
                r_mode <= mode_e'(MemBus_Write_Data[CFG_MODE]);
                r_ien  <= MemBus_Write_Data[CFG_IEN];
            end
        end
    end

    // Hardware set beats a same-edge software clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_irq <= r_done && r_ien;
            if (w_load)
                r_done <= 1'b0;
            else if (w_finish)
                r_done <= 1'b1;
            else if (w_w1c && MemBus_Write_Data[STAT_DONE])
                r_done <= 1'b0;
            if (w_load)
                r_ovf <= 1'b0;
            else if (w_dp_ovf)
                r_ovf <= 1'b1;
            else if (w_w1c && MemBus_Write_Data[STAT_OVF])
                r_ovf <= 1'b0;
        end
    end

    assign irq = r_irq;

    series_datapath #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_dp (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_step (w_step),
        .i_mode (r_mode),
        .i_x    (r_op),
        .i_n    (r_nterms),
        .o_ans  (w_ans),
        .o_ovf  (w_dp_ovf),
        .o_last (w_dp_last)
    );

    always_comb begin
        w_rdata = '0;
        if (MemRead) begin
            if (w_hit_op)
                w_rdata = r_op;
            else if (w_hit_ans)
                w_rdata = w_ans;
            else if (w_hit_ctrl)
                w_rdata[0] = w_busy;
            else if (w_hit_nterms)
                w_rdata[CNT_W-1:0] = r_nterms;
            else if (w_hit_cfg) begin
                w_rdata[CFG_MODE] = r_mode;
                w_rdata[CFG_IEN]  = r_ien;
            end else if (w_hit_status) begin
                w_rdata[STAT_DONE] = r_done;
                w_rdata[STAT_OVF]  = r_ovf;
                w_rdata[STAT_BUSY] = w_busy;
            end
        end
    end

    assign Device_Read_Data = w_rdata;

endmodule

// File: tb/tb_mmio_series_accel.sv
// Directed bench for mmio_series_accel: a table of series runs with hand-computed
// results, then hand sequences for busy-write blocking, W1C races, irq and reset.
module tb_mmio_series_accel;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mmio_series_accel dut (
        .clk               (clk),
        .reset             (reset),
        .MemRead           (MemRead),
        .MemWrite          (MemWrite),
        .MemBus_Address    (addr),
        .MemBus_Write_Data (wdata),
        .Device_Read_Data  (rdata),
        .irq               (irq)
    );

    typedef struct {
        logic [31:0] op;
        logic [31:0] n;
        logic        mode;
        logic [31:0] ans;
        logic        ovf;
        int          edges;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        @(negedge clk);
        MemWrite = 1'b1;
        addr     = BASE + off;
        wdata    = d;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        MemRead = 1'b1;
        addr    = a;
        #1;
        d       = rdata;
        MemRead = 1'b0;
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] d);
        @(negedge clk);
        peek(BASE + off, d);
    endtask

    task automatic start_run(input logic [31:0] op, input logic [31:0] n, input logic [31:0] cfg);
        wr(32'h00, op);
        wr(32'h0C, n);
        wr(32'h10, cfg);
        wr(32'h08, 32'h1);
    endtask

    task automatic wait_idle(output int edges);
        logic [31:0] s;
        edges = 0;
        rd(32'h14, s);
        while (s[2] && edges < 100) begin
            @(posedge clk);
            edges++;
            rd(32'h14, s);
        end
    endtask

    initial begin
        logic [31:0] d;
        int          e;

        vt[0] = '{op: 32'd2,          n: 32'd5,  mode: 1'b0, ans: 32'd31,        ovf: 1'b0, edges: 5};
        vt[1] = '{op: 32'd3,          n: 32'd3,  mode: 1'b1, ans: 32'd9,         ovf: 1'b0, edges: 3};
        vt[2] = '{op: 32'd5,          n: 32'd0,  mode: 1'b1, ans: 32'd1,         ovf: 1'b0, edges: 1};
        vt[3] = '{op: 32'h0001_0000,  n: 32'd3,  mode: 1'b0, ans: 32'h0001_0001, ovf: 1'b1, edges: 3};
        vt[4] = '{op: 32'd3,          n: 32'd4,  mode: 1'b0, ans: 32'd40,        ovf: 1'b0, edges: 4};
        vt[5] = '{op: 32'hFFFF_FFFF,  n: 32'd2,  mode: 1'b0, ans: 32'd0,         ovf: 1'b1, edges: 2};
        vt[6] = '{op: 32'd2,          n: 32'd20, mode: 1'b1, ans: 32'h0000_8000, ovf: 1'b0, edges: 16};
        vt[7] = '{op: 32'd2,          n: 32'd16, mode: 1'b0, ans: 32'h0000_FFFF, ovf: 1'b0, edges: 16};

        reset    = 1'b1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        addr     = '0;
        wdata    = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        rd(32'h00, d); check("rst op", d, 32'd0);
        rd(32'h04, d); check("rst ans", d, 32'd0);
        rd(32'h08, d); check("rst ctrl", d, 32'd0);
        rd(32'h0C, d); check("rst nterms", d, 32'd5);
        rd(32'h10, d); check("rst cfg", d, 32'd0);
        rd(32'h14, d); check("rst status", d, 32'd0);
        check("rst irq", {31'b0, irq}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            start_run(vt[i].op, vt[i].n, {31'b0, vt[i].mode});
            wait_idle(e);
            check($sformatf("v%0d edges", i), e, vt[i].edges);
            rd(32'h04, d);
            check($sformatf("v%0d ans", i), d, vt[i].ans);
            rd(32'h14, d);
            check($sformatf("v%0d status", i), d, {30'b0, vt[i].ovf, 1'b1});
        end

        // Writes to OP and START while running are dropped.
        start_run(32'd2, 32'd5, 32'd0);
        wr(32'h00, 32'd7);
        wr(32'h08, 32'd1);
        wait_idle(e);
        check("busy-wr edges", e, 3);
        rd(32'h04, d); check("busy-wr ans", d, 32'd31);
        rd(32'h00, d); check("busy-wr op", d, 32'd2);

        // W1C landing on the completion edge loses to the done set.
        start_run(32'd1, 32'd3, 32'd0);
        repeat (2) @(posedge clk);
        wr(32'h14, 32'h3);
        rd(32'h14, d); check("w1c race status", d, 32'd1);
        rd(32'h04, d); check("w1c race ans", d, 32'd3);

        // Interrupt follows done by one edge and clears after W1C.
        start_run(32'd1, 32'd2, 32'h2);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("irq at done edge", {31'b0, irq}, 32'd0);
        rd(32'h14, d); check("irq done set", d, 32'd1);
        @(posedge clk);
        #1;
        check("irq raised", {31'b0, irq}, 32'd1);
        wr(32'h14, 32'h1);
        @(posedge clk);
        #1;
        check("irq cleared", {31'b0, irq}, 32'd0);
        rd(32'h14, d); check("w1c status", d, 32'd0);

        // Reset mid-run drops everything without waiting for a clock edge.
        start_run(32'd1, 32'd2, 32'h2);
        wait_idle(e);
        @(posedge clk);
        #1;
        check("irq second run", {31'b0, irq}, 32'd1);
        start_run(32'd2, 32'd5, 32'h2);
        check("irq at restart", {31'b0, irq}, 32'd1);
        peek(BASE + 32'h14, d); check("busy pre-reset", d, 32'd4);
        reset = 1'b1;
        #1;
        check("irq async reset", {31'b0, irq}, 32'd0);
        peek(BASE + 32'h14, d); check("status in reset", d, 32'd0);
        peek(BASE + 32'h04, d); check("ans in reset", d, 32'd0);
        peek(BASE + 32'h10, d); check("cfg in reset", d, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Clamping and decode boundaries.
        wr(32'h0C, 32'd20);
        rd(32'h0C, d); check("nterms clamp hi", d, 32'd16);
        wr(32'h0C, 32'd0);
        rd(32'h0C, d); check("nterms clamp 0", d, 32'd1);
        rd(32'h18, d); check("unmapped read", d, 32'd0);
        start_run(32'd2, 32'd5, 32'd0);
        wait_idle(e);
        rd(32'h04, d); check("ans readable", d, 32'd31);
        @(negedge clk);
        MemRead = 1'b0;
        addr    = BASE + 32'h04;
        #1;
        check("ans no MemRead", rdata, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
